// File: rtl/apb_master_bridge.sv
// APB3 requester: accepts one command at a time on a valid/ready interface,
// runs it as a SETUP + ACCESS transfer, and reports completion on a
// one-cycle response strobe (read data, slave error, timeout).
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] Paddr,
    output logic              Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [DATA_W-1:0] Pwdata,
    input  logic              Pready,
    input  logic              Pslverr,
    input  logic [DATA_W-1:0] Prdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Wait counter only needs to reach TIMEOUT; keep at least one bit so a
    // disabled timeout still elaborates cleanly.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // Saturating increment so a long stall never wraps the wait counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                pen_q, pen_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_to_q, rsp_to_d;
    logic                timeout_hit;

    // The edge on which the counter would reach TIMEOUT with the slave still
    // stalling; a ready slave on that same edge completes normally instead.
    assign timeout_hit = (TIMEOUT != 0) && !Pready && (wait_q == TO_LAST);

    // State register: reset drops back to IDLE immediately, losing any transfer.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: SETUP always lasts one cycle; ACCESS ends on ready or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_valid) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (Pready || timeout_hit) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output next-state: APB signals hold unless the FSM changes phase, and
    // response fields default to zero so they only live for one cycle.
    always_comb begin
        wait_d      = wait_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        pen_d       = pen_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    wait_d   = '0;
                end
            end
            S_SETUP: begin
                pen_d = 1'b1;
            end
            S_ACCESS: begin
                if (Pready) begin
                    psel_d      = 1'b0;
                    pen_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = Pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : Prdata;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    pen_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    wait_d = sat_inc(wait_q);
                end
            end
            default: begin
                psel_d = 1'b0;
                pen_d  = 1'b0;
            end
        endcase
    end

    // Registered APB and response outputs, all cleared asynchronously by reset.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            wait_q      <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            pen_q       <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            pen_q       <= pen_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign Paddr       = paddr_q;
    assign Pselx       = psel_q;
    assign Penable     = pen_q;
    assign Pwrite      = pwrite_q;
    assign Pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester: turns a simple valid/ready command interface into APB3 transfers (SETUP then ACCESS) toward the APB memory/slave blocks.
- Returns read data, slave error and a timeout indication on a one-cycle response strobe.
- Sits between the test/CPU-side command source and the APB slave.
- Handles one outstanding transfer at a time.

Parameters:
- ADDR_W, 32, width of Paddr and cmd_addr.
- DATA_W, 32, width of Pwdata, Prdata, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles with Pready=0 before abort; 0 disables the timeout.

Ports:
- Pclk  in  1  APB clock.
- Prst  in  1  reset: asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid at posedge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  Pslverr captured, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  high in SETUP or ACCESS.
- Paddr  out  ADDR_W  APB address.
- Pselx  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  slave ready.
- Pslverr  in  1  slave error.
- Prdata  in  DATA_W  slave read data.

Behaviour:
- Reset (Prst=0, async): state IDLE, wait counter 0. All registered outputs go to 0: Paddr, Pselx, Penable, Pwrite, Pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout. busy=0; cmd_ready=1 once in IDLE.
- Reset mid-transfer: bus deasserts immediately, no response is issued, and the command is lost.
- States are IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready = (state==IDLE), combinational from state. Command inputs are ignored outside IDLE.
- IDLE -> SETUP on cmd_valid & cmd_ready at posedge.
  - Latch the command.
  - Next cycle: Pselx=1, Penable=0, Paddr=cmd_addr, Pwrite=cmd_write.
  - Pwdata=cmd_wdata for writes, 0 for reads.
- SETUP -> ACCESS unconditionally after 1 cycle: Penable=1. Pready and Pslverr are ignored in SETUP.
- ACCESS, Pready=1 at posedge: transfer completes.
  - Next cycle: Pselx=0, Penable=0, state IDLE.
  - rsp_valid=1 for exactly 1 cycle; rsp_err=Pslverr; rsp_timeout=0.
  - rsp_rdata=Prdata if read, else 0.
  - Paddr, Pwrite and Pwdata hold their last values until the next SETUP.
- ACCESS, Pready=0: stay in ACCESS and increment the wait counter.
  - Paddr, Pwrite, Pwdata, Pselx and Penable are held stable.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with Pready still 0: abort. Next cycle Pselx=0, Penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state IDLE.
  - If Pready=1 on the same edge the counter reaches TIMEOUT, normal completion wins.
- Wait counter: clears on entering SETUP; width sized to hold TIMEOUT; no wrap (saturates).
- rsp_err, rsp_rdata and rsp_timeout are valid only while rsp_valid=1; they are cleared to 0 the cycle after.
- Latency, zero wait states: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid cycle N+3.
  - cmd_ready=1 again in cycle N+3.
  - Minimum 3 cycles per transfer, with one idle APB cycle between transfers.
- busy = (state!=IDLE).

Test Plan:
- Reset then idle: Prst=0 for 2 cycles with cmd_valid=1 -> all APB outputs 0, rsp_valid=0; cmd_ready=1 after release.
- Write, zero wait: cmd write addr 0x04, data 0xDEADBEEF, Pready tied 1.
  - SETUP: Pselx=1, Penable=0, Paddr=0x04, Pwrite=1.
  - ACCESS the next cycle.
  - rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: cmd read addr 0x04, Pready low for 2 ACCESS cycles then high, Prdata=0xDEADBEEF.
  - Penable high for 3 cycles with Paddr stable.
  - rsp_rdata=0xDEADBEEF, rsp_valid 5 cycles after accept.
- Slave error: Pslverr=1 with Pready=1 on a read of addr 0x1F -> rsp_err=1, rsp_timeout=0, rsp_valid for 1 cycle.
- Timeout: TIMEOUT=16, Pready held 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, Pselx=0 the next cycle. A repeat with Pready=1 on the 16th edge completes normally.
- Async reset in ACCESS: assert Prst mid-wait -> Pselx/Penable drop without waiting for a clock edge, no rsp_valid; the next command runs normally.
